// File: rtl/rfsoc_config.sv
// Shared RFSoC PL configuration package.
// Holds the gpio control-bus bit map, the waveform player state type and
// default widths used by the DAC playback channels.
package rfsoc_config;

  // gpio_ctrl bit map
  localparam int unsigned pl_rst       = 0;
  localparam int unsigned trigger_line = 1;
  localparam int unsigned wave_load    = 2;
  localparam int unsigned play_loop    = 3;

  // Default datapath geometry: 16 DAC samples x 16 bit, 1024-word waveform
  localparam int DEF_DATA_W = 256;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_CTRL_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ARMED,
    PLAY
  } player_state_t;

endpackage

// File: rtl/dac_wave_player_if.sv
// AXI4-Stream style bundle used for the player's load and DAC ports.
//   tdata  : sample word (DATA_W bits)
//   tvalid : source has a word
//   tready : sink accepts the word
// master drives tdata/tvalid, slave drives tready.
interface dac_wave_player_if
  import rfsoc_config::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/dac_wave_player_ram.sv
// Simple dual-port waveform RAM: one write port, one registered read port
// with 1-cycle latency. Written as plain arrays so it maps onto block RAM.
//   clk   : clock
//   we    : write enable, waddr/wdata : write port
//   re    : read enable,  raddr       : read address
//   rdata : read data, valid the cycle after re
module wave_ram
  import rfsoc_config::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dac_wave_player.sv
// Per-channel DAC waveform player.
// Captures a waveform from s_axis into local RAM while the channel is
// selected and loading is enabled, then replays it on m_axis at one word per
// cycle on each rising edge of trigger, once or looped.
//   pl_clk, rst   : clock, synchronous active-low reset
//   gpio_ctrl     : control bus (wave_load / play_loop bits)
//   chan_sel      : this channel is the load target
//   trigger       : playback trigger level
//   s_axis        : load stream (slave)
//   m_axis        : DAC sample stream (master), tdata is 0 while tvalid=0
//   wave_len      : stored word count 0..2**ADDR_W
//   busy          : high while loading or playing
module dac_wave_player
  import rfsoc_config::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              pl_clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] gpio_ctrl,
  input  logic              chan_sel,
  input  logic              trigger,
  dac_wave_player_if.slave  s_axis,
  dac_wave_player_if.master m_axis,
  output logic [ADDR_W:0]   wave_len,
  output logic              busy
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(2**ADDR_W);

  player_state_t     state_q, state_nx;
  logic              trig_q;
  logic              load_req, loop_en, trig_edge;
  logic              s_ready, accept, issue, flush, clr_len, push, pop;
  logic              issue_last;
  logic [ADDR_W-1:0] rd_ptr_q, rd_addr;
  logic [2:0]        occ;
  logic              ctrl_unused;

  logic              vld_p0, last_p0;
  logic [DATA_W-1:0] ram_q_p0;
  logic [DATA_W-1:0] dat_p1 [2];
  logic [1:0]        lst_p1;
  logic [1:0]        cnt_p1;

  assign load_req    = gpio_ctrl[wave_load] & chan_sel;
  assign loop_en     = gpio_ctrl[play_loop];
  assign ctrl_unused = ^gpio_ctrl;
  assign trig_edge   = trigger & ~trig_q;

  assign pop  = (cnt_p1 != 2'd0) & m_axis.tready;
  assign push = vld_p0 & ~flush;
  // Words held in the skid plus the one returning from RAM, after this pop
  assign occ  = 3'(cnt_p1) + 3'(vld_p0) - 3'(pop);

  // The trigger cycle itself reads word 0 so the first word appears two
  // cycles after the edge.
  assign rd_addr    = (state_q == PLAY) ? rd_ptr_q : '0;
  assign issue_last = ({1'b0, rd_addr} == wave_len - (ADDR_W+1)'(1));

  always_comb begin
    state_nx = state_q;
    s_ready  = 1'b0;
    accept   = 1'b0;
    issue    = 1'b0;
    flush    = 1'b0;
    clr_len  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_req) begin
          state_nx = LOAD;
          clr_len  = 1'b1;
        end else if (wave_len != '0) begin
          state_nx = ARMED;
        end
      end
      LOAD: begin
        s_ready = (wave_len < DEPTH_L);
        accept  = s_ready & s_axis.tvalid;
        if (!load_req) state_nx = ((wave_len != '0) || accept) ? ARMED : IDLE;
      end
      ARMED: begin
        if (load_req) begin
          state_nx = LOAD;
          clr_len  = 1'b1;
        end else if (trig_edge) begin
          state_nx = PLAY;
          issue    = 1'b1;
        end
      end
      PLAY: begin
        if (load_req) begin
          state_nx = LOAD;
          clr_len  = 1'b1;
          flush    = 1'b1;
        end else if (pop && lst_p1[0] && !loop_en) begin
          state_nx = ARMED;
          flush    = 1'b1;
        end else begin
          // Read ahead only while the 2-entry skid can absorb the result
          issue = (occ < 3'd2);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge pl_clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      trig_q   <= 1'b0;
      wave_len <= '0;
      rd_ptr_q <= '0;
      vld_p0   <= 1'b0;
      cnt_p1   <= 2'd0;
    end else begin
      state_q <= state_nx;
      trig_q  <= trigger;
      if (clr_len)     wave_len <= '0;
      else if (accept) wave_len <= wave_len + (ADDR_W+1)'(1);
      if (issue) rd_ptr_q <= issue_last ? '0 : rd_addr + ADDR_W'(1);
      vld_p0 <= issue;
      if (flush) cnt_p1 <= 2'd0;
      else       cnt_p1 <= cnt_p1 + 2'(push) - 2'(pop);
    end
  end

  // ---- p0: RAM read returns, tagged with end-of-waveform ----
  wave_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (pl_clk),
    .we    (accept),
    .waddr (wave_len[ADDR_W-1:0]),
    .wdata (s_axis.tdata),
    .re    (issue),
    .raddr (rd_addr),
    .rdata (ram_q_p0)
  );

  // ---- p1: 2-entry output skid, slot 0 is the head ----
  always_ff @(posedge pl_clk) begin
    last_p0 <= issue_last;
    if (pop) begin
      dat_p1[0] <= dat_p1[1];
      lst_p1[0] <= lst_p1[1];
    end
    if (push) begin
      if (cnt_p1 == 2'd0 || (cnt_p1 == 2'd1 && pop)) begin
        dat_p1[0] <= ram_q_p0;
        lst_p1[0] <= last_p0;
      end else begin
        dat_p1[1] <= ram_q_p0;
        lst_p1[1] <= last_p0;
      end
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = (cnt_p1 != 2'd0);
  assign m_axis.tdata  = m_axis.tvalid ? dat_p1[0] : '0;
  assign busy          = (state_q == LOAD) || (state_q == PLAY);

endmodule

// File: doc/dac_wave_player.md
Name: dac_wave_player

Overview:
- Per-channel waveform playback stage between the per-channel AXIS fan-out (256-bit words from the PS crossing) and one RFSoC DAC AXIS input.
- Captures a waveform into local block RAM while its channel is selected and loading is enabled.
- Replays the waveform at full DAC rate on a rising edge of the trigger line, once or looped.
- Sixteen instances are used, one per DAC tile channel.

Parameters:
- DATA_W, 256, AXIS word width (16 DAC samples x 16 bit)
- ADDR_W, 10, RAM address width; DEPTH = 2**ADDR_W words
- CTRL_W, 16, width of the gpio control bus

Ports:
- pl_clk  in  1  PL clock; single clock domain
- rst  in  1  synchronous, active-low reset
- gpio_ctrl  in  CTRL_W  control bus, already in the pl_clk domain
- chan_sel  in  1  this channel is the current write target
- trigger  in  1  playback trigger level (gpio trigger line)
- s_axis_tdata  in  DATA_W  load data
- s_axis_tvalid  in  1  load valid
- s_axis_tready  out  1  load ready
- m_axis_tdata  out  DATA_W  DAC sample word
- m_axis_tvalid  out  1  DAC valid
- m_axis_tready  in  1  DAC ready
- wave_len  out  ADDR_W+1  number of stored words, 0..DEPTH
- busy  out  1  high in the LOAD or PLAY state

Behaviour:
- Control bits come from gpio_ctrl: load_en = gpio_ctrl[wave_load], loop_en = gpio_ctrl[play_loop]. Bit indices are defined in the package.
- Reset (rst=0 at a pl_clk edge) takes effect on the next cycle:
  - state=IDLE
  - wave_len=0, write and read pointers=0
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, busy=0
  - trigger edge register=0
  - Reset mid-load or mid-play aborts immediately; RAM contents are don't-care.
- m_axis_tdata is forced to 0 whenever m_axis_tvalid=0, so the DAC idles at midscale.
- IDLE:
  - On load_en & chan_sel -> LOAD, clearing the write pointer and wave_len.
  - If wave_len>0 and no load is requested -> ARMED.
- LOAD:
  - s_axis_tready = (wave_len < DEPTH).
  - On tvalid&tready: write RAM[wave_len], wave_len+1.
  - Full (wave_len=DEPTH): tready=0; further words are back-pressured, never dropped or overwritten.
  - When load_en=0 or chan_sel=0: go to ARMED if wave_len>0, else IDLE. A beat accepted in that same cycle is still written.
- ARMED:
  - trig_q registers trigger every cycle; rising edge = trigger & ~trig_q.
  - On a rising edge -> PLAY with read pointer=0.
  - On load_en & chan_sel -> LOAD, which takes priority over a simultaneous trigger.
- PLAY:
  - RAM read latency is 1 cycle. The first m_axis_tvalid is asserted exactly 2 cycles after the cycle in which the rising edge is sampled.
  - Words 0..wave_len-1 are presented in order.
  - Each word is held stable until m_axis_tvalid&m_axis_tready.
  - Sustained throughput is 1 word/cycle while tready=1.
  - A 2-entry output skid/prefetch ensures no bubbles and no duplicated or dropped words under arbitrary tready toggling.
  - After the last word handshakes:
    - loop_en=1: wrap to word 0 with no idle cycle.
    - loop_en=0: -> ARMED, tvalid=0 the next cycle.
  - Trigger edges during PLAY are ignored. loop_en is sampled at each wrap point.
  - load_en & chan_sel during PLAY aborts playback: tvalid=0 the next cycle, pipeline flushed, -> LOAD.
  - wave_len=1 with loop_en: the same word is repeated every cycle.
- busy = (state==LOAD) | (state==PLAY).
- wave_len holds its value across playback and is cleared only by reset or a new LOAD.

Decomposition:
- Shared package rfsoc_config gains:
  - gpio bit indices wave_load and play_loop, alongside the existing pl_rst and trigger_line
  - typedef enum player_state_t {IDLE, LOAD, ARMED, PLAY}
  - constants for default data width and RAM depth
- One sub-module: wave_ram, a simple dual-port RAM (1 write port, 1 registered read port, 1-cycle latency, DATA_W x DEPTH, block-RAM inference).

Test Plan:
- Load with chan_sel=1, load_en=1: send 4 words 0x1,0x2,0x3,0x4, then drop load_en -> wave_len=4, state ARMED, s_axis_tready=0, busy=0.
- Trigger 0->1 with tready=1 -> m_axis_tvalid first high 2 cycles after the edge; words 1,2,3,4 on consecutive cycles; then tvalid=0 and tdata=0; a second trigger replays identically.
- loop_en=1 and trigger -> 1,2,3,4,1,2,3,4... with no gap. Clearing loop_en stops the output after the next word 4 handshake.
- Random tready (about 50% duty) over a 16-word looped waveform for 1000 cycles -> scoreboard shows exact sequence order with no drops or duplicates, and tdata is stable while valid&~ready.
- ADDR_W=3 (DEPTH=8): offer 10 words -> tready low after 8 accepts, wave_len=8; playback returns words 1..8 only.
- rst=0 mid-PLAY -> next cycle tvalid=0, wave_len=0, busy=0. With chan_sel=0 and load_en=1, no words are accepted (tready stays 0).
